// File: rtl/hex_display_scan.sv
// hex_display_scan
//
// Time-multiplexes four hex count digits onto a common-anode 4-digit
// seven-segment display. Each scan frame takes a coherent snapshot of all
// four digits at its start, so a carry in the counter partway through a
// frame never appears as a torn value. While pause is high the display
// blinks, and the decimal point of digit 0 is lit.
//
// Optional feature: define HEX_DISPLAY_SCAN_LZB_EN to blank the leading
// zeros of the snapshot. Digit 0 is never blanked. A blanked slot still
// takes its full scan time.
//
// Parameters:
//   REFRESH_BITS  refresh counter width. Each digit is lit for
//                 2^(REFRESH_BITS-2) clocks. Must be at least 3.
//   BLINK_BITS    blink counter width. The blink half-period is
//                 2^(BLINK_BITS-1) clocks. Must be at least 2.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   hex0..hex3   count digits, hex0 least significant
//   pause        counter-paused flag, level-sensitive
//   an[3:0]      digit enables, active-low (an[i]=0 lights digit i)
//   sseg[7:0]    segments, active-low, {dp,g,f,e,d,c,b,a}
module hex_display_scan #(
    parameter int REFRESH_BITS = 18,
    parameter int BLINK_BITS   = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hex0,
    input  logic [3:0] hex1,
    input  logic [3:0] hex2,
    input  logic [3:0] hex3,
    input  logic       pause,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam logic [REFRESH_BITS-1:0] Q_ONE = REFRESH_BITS'(1);
    localparam logic [BLINK_BITS-1:0]   B_ONE = BLINK_BITS'(1);

    logic [REFRESH_BITS-1:0] q_reg;
    logic [BLINK_BITS-1:0]   b_reg;
    logic [3:0]              snap_reg [4];
    logic [3:0]              hex_in   [4];
    logic [3:0]              an_reg, an_next;
    logic [7:0]              sseg_reg, sseg_next;

    logic [1:0] idx;
    logic       frame_end;
    logic       blink_off;
    logic [3:0] lead_blank;
    logic       slot_blank;
    logic [3:0] cur_digit;

    assign hex_in[0] = hex0;
    assign hex_in[1] = hex1;
    assign hex_in[2] = hex2;
    assign hex_in[3] = hex3;

    // The top two refresh bits select the digit, so each digit owns a
    // contiguous quarter of the refresh period.
    assign idx       = q_reg[REFRESH_BITS-1 -: 2];
    // The edge that wraps q back to zero is also the start of a new frame.
    assign frame_end = &q_reg;
    assign blink_off = b_reg[BLINK_BITS-1];

`ifdef HEX_DISPLAY_SCAN_LZB_EN
    logic [3:0] digit_zero;

    for (genvar gi = 0; gi < 4; gi++) begin : g_zero
        assign digit_zero[gi] = (snap_reg[gi] == 4'h0);
    end

    // A digit is a leading zero only when it and every more significant
    // digit are zero. Digit 0 always shows, so "0" is displayed for zero.
    assign lead_blank = {digit_zero[3],
                         &digit_zero[3:2],
                         &digit_zero[3:1],
                         1'b0};
`else
    assign lead_blank = 4'b0000;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b0000011;
            4'hC:    decode = 7'b1000110;
            4'hD:    decode = 7'b0100001;
            4'hE:    decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        cur_digit  = snap_reg[idx];
        slot_blank = lead_blank[idx];
        an_next    = 4'b1111;
        if (!(slot_blank || (pause && blink_off))) begin
            an_next[idx] = 1'b0;
        end
        sseg_next[6:0] = slot_blank ? 7'h7F : decode(cur_digit);
        sseg_next[7]   = ~((idx == 2'd0) && pause);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg    <= '0;
            b_reg    <= '0;
            an_reg   <= 4'b1111;
            sseg_reg <= 8'hFF;
            for (int i = 0; i < 4; i++) begin
                snap_reg[i] <= 4'h0;
            end
        end else begin
            q_reg    <= q_reg + Q_ONE;
            b_reg    <= b_reg + B_ONE;
            an_reg   <= an_next;
            sseg_reg <= sseg_next;
            if (frame_end) begin
                for (int i = 0; i < 4; i++) begin
                    snap_reg[i] <= hex_in[i];
                end
            end
        end
    end

    assign an   = an_reg;
    assign sseg = sseg_reg;

endmodule

// File: tb/tb_hex_display_scan.sv
// Testbench for hex_display_scan with REFRESH_BITS=4, BLINK_BITS=3.
// A cycle-count model predicts an/sseg every clock; directed literal
// expectations pin the model to the documented behaviour.
module tb_hex_display_scan;

    localparam int RB = 4;
    localparam int BB = 3;
`ifdef HEX_DISPLAY_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk;
    logic       reset;
    logic [3:0] hex0, hex1, hex2, hex3;
    logic       pause;
    logic [3:0] an;
    logic [7:0] sseg;

    int checks = 0;
    int errors = 0;
    int t      = 0;
    bit run_cmp = 1'b0;

    hex_display_scan #(
        .REFRESH_BITS(RB),
        .BLINK_BITS  (BB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hex0 (hex0),
        .hex1 (hex1),
        .hex2 (hex2),
        .hex3 (hex3),
        .pause(pause),
        .an   (an),
        .sseg (sseg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] req, input bit verbose);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0d", nm, act, req, t);
        end else if (verbose) begin
            $display("check %s ok value=%h t=%0d", nm, act, t);
        end
    endtask

    // Behavioural model: the display state is a pure function of how many
    // clocks have elapsed since reset release plus the frame snapshot.
    int         cnt = 0;
    logic [3:0] msnap [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] exp_an   = 4'hF;
    logic [7:0] exp_sseg = 8'hFF;

    always @(posedge clk or negedge reset) begin
        int  qv;
        int  di;
        bit  boff;
        bit  lb;
        if (!reset) begin
            cnt      = 0;
            msnap    = '{4'h0, 4'h0, 4'h0, 4'h0};
            exp_an   = 4'hF;
            exp_sseg = 8'hFF;
        end else begin
            qv   = cnt % (1 << RB);
            di   = qv >> (RB - 2);
            boff = (cnt % (1 << BB)) >= (1 << (BB - 1));
            lb   = 1'b0;
            if (LZB && di > 0) begin
                lb = 1'b1;
                for (int j = di; j < 4; j++) begin
                    if (msnap[j] != 4'h0) lb = 1'b0;
                end
            end
            exp_an = 4'hF;
            if (!lb && !(pause && boff)) exp_an[di] = 1'b0;
            exp_sseg = {!(di == 0 && pause), lb ? 7'h7F : DEC[msnap[di]]};
            if (qv == (1 << RB) - 1) msnap = '{hex0, hex1, hex2, hex3};
            cnt++;
        end
    end

    always @(negedge clk) begin
        #2;
        if (run_cmp) begin
            chk("model_an", {4'h0, an}, {4'h0, exp_an}, 1'b0);
            chk("model_sseg", sseg, exp_sseg, 1'b0);
        end
    end

    task automatic step_to(input int k);
        while (t < k) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic lit(input string nm, input logic [3:0] ea, input logic [7:0] es);
        chk({nm, "_an"}, {4'h0, an}, {4'h0, ea}, 1'b1);
        chk({nm, "_sseg"}, sseg, es, 1'b1);
    endtask

    task automatic restart(input logic [3:0] h3, input logic [3:0] h2,
                           input logic [3:0] h1, input logic [3:0] h0,
                           input logic p);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        hex3  = h3; hex2 = h2; hex1 = h1; hex0 = h0;
        pause = p;
        reset = 1'b1;
        t     = 0;
    endtask

    initial begin
        logic [3:0] scan_an [5];
        logic [7:0] blank_or_zero;
        scan_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        blank_or_zero = LZB ? 8'hFF : 8'hC0;

        reset = 1'b0; pause = 1'b0;
        hex0 = 4'h0; hex1 = 4'h0; hex2 = 4'h0; hex3 = 4'h0;
        repeat (3) @(negedge clk);
        run_cmp = 1'b1;
        lit("reset", 4'hF, 8'hFF);

        // Scan order from release with all-zero digits
        reset = 1'b1;
        t = 0;
        for (int i = 0; i < 5; i++) begin
            step_to(1 + 4 * i);
            if (i == 0 || i == 4 || !LZB)
                lit("scan", scan_an[i], 8'hC0);
            else
                lit("scan_lzb", 4'hF, 8'hFF);
        end

        // Snapshot F,A,0,1: first frame still zero, second frame shows it
        restart(4'hF, 4'hA, 4'h0, 4'h1, 1'b0);
        step_to(1);  lit("frame1_d0", 4'b1110, 8'hC0);
        step_to(17); lit("frame2_d0", 4'b1110, 8'hF9);
        step_to(21); lit("frame2_d1", 4'b1101, 8'hC0);
        step_to(25); lit("frame2_d2", 4'b1011, 8'h88);
        hex0 = 4'h2;
        step_to(29); lit("frame2_d3", 4'b0111, 8'h8E);
        step_to(33); lit("frame3_d0", 4'b1110, 8'hA4);

        // Pause blink with digits 4,3,2,1
        restart(4'h4, 4'h3, 4'h2, 4'h1, 1'b1);
        step_to(1);  lit("pause_f1_d0", 4'b1110, 8'h40);
        step_to(17); lit("pause_d0", 4'b1110, 8'h79);
        step_to(21); lit("pause_d1_blink", 4'b1111, 8'hA4);
        step_to(25); lit("pause_d2", 4'b1011, 8'hB0);
        step_to(29); lit("pause_d3_blink", 4'b1111, 8'h99);
        step_to(33); lit("pause_d0_dp", 4'b1110, 8'h79);
        pause = 1'b0;
        step_to(34); lit("unpause_d0", 4'b1110, 8'hF9);

        // Reset during the digit-2 slot
        step_to(43);
        lit("pre_reset_d2", 4'b1011, 8'hB0);
        reset = 1'b0;
        #1;
        lit("async_reset", 4'hF, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        t = 0;
        step_to(1); lit("resume_d0", 4'b1110, 8'hC0);
        step_to(5); lit("resume_d1", LZB ? 4'b1111 : 4'b1101, blank_or_zero);

        // Leading zeros 0,0,3,7 then all zero
        restart(4'h0, 4'h0, 4'h3, 4'h7, 1'b0);
        step_to(17); lit("lz_d0", 4'b1110, 8'hF8);
        step_to(21); lit("lz_d1", 4'b1101, 8'hB0);
        step_to(25); lit("lz_d2", LZB ? 4'b1111 : 4'b1011, blank_or_zero);
        step_to(29); lit("lz_d3", LZB ? 4'b1111 : 4'b0111, blank_or_zero);
        hex0 = 4'h0; hex1 = 4'h0;
        step_to(33); lit("zero_d0", 4'b1110, 8'hC0);
        step_to(37); lit("zero_d1", LZB ? 4'b1111 : 4'b1101, blank_or_zero);

        step_to(40);
        run_cmp = 1'b0;
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
